fpu_output_cvt: RTL
===================

// Module: fpu_output_cvt
// PURPOSE
//  Writeback converter for the FPU: turns a 64-bit signed fixed-point FPU result (Q15, 16 int bits incl. sign,
//  48 frac bits, 1.0 = 64'h0001_0000_0000_0000) into a 32-bit general-register value as fp32, u32 or i32.
//  Sits between the FPU result bus and the general register write port; inverse of the FPU input selection path.
//  Iterative (1 bit/cycle) normaliser for fp32; valid/ready handshake on both sides.
// PARAMETERS
//  FRAC_BITS  48   fraction bits of in_data; integer part is in_data[63:FRAC_BITS]
//  FP_BIAS    127  fp32 exponent bias
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   in_dst/in_data valid
//  in_ready   out  1   converter idle, accepts input
//  in_dst     in   2   2'b00 fp32, 2'b01 u32, 2'b10 i32, 2'b11 illegal
//  in_data    in   64  signed Q15 FPU result
//  out_valid  out  1   out_data/out_err valid
//  out_ready  in   1   consumer takes result
//  out_data   out  32  converted result
//  out_err    out  1   1 = illegal in_dst
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, internal regs=0.
//  FSM: IDLE -> (accept) NORM (fp32, nonzero) | DONE (others); NORM -> DONE when mag[63]=1; DONE -> IDLE on out_ready.
//  Accept = in_valid & in_ready at a rising edge; in_ready = (state==IDLE), registered-state-based only.
//  No accept in DONE: one conversion in flight; in_ready rises the cycle after the out handshake.
//  out_valid = (state==DONE); out_data/out_err stable while out_valid=1 and out_ready=0.
//  u32 (01): negative -> 0; else zero-extended integer part in_data[63:48] (fraction truncated); max 32'h0000_7FFF.
//  i32 (10): truncate toward zero: sign-extend in_data[63:48]; if negative and in_data[47:0]!=0 add 1.
//  illegal (11): out_data=0, out_err=1. Int/illegal: result latched at accept, out_valid high after edge k+1.
//  fp32 (00): sign=in_data[63]; mag = two's-complement magnitude as unsigned 64 (-2^63 -> 64'h8000_0000_0000_0000).
//   mag==0 -> out_data=32'h0000_0000 (+0, sign dropped), DONE at edge k+1.
//   Else load mag, exp=FP_BIAS+63-FRAC_BITS (142) at accept; in NORM each edge: if mag[63] pack
//   {sign, exp[7:0], mag[62:40]} and go DONE, else mag<<=1, exp-=1.
//   Mantissa truncated (round toward zero); no subnormal/overflow possible (exp range 79..142).
//   Latency: leading one at bit p -> out_valid high after edge k+2+(63-p); worst case p=0 -> k+65.
//  Reset asserted in any state aborts the conversion immediately; no partial result is ever presented.
//  out_ready while out_valid=0 is ignored; in_valid while in_ready=0 is ignored (input not captured).
// TESTING
//  Reset mid-stream -> in_ready=1, out_valid=0, out_data=0 while rst_n=0; first accept after release works.
//  fp32 in 64'h0001_0000_0000_0000 -> 32'h3F80_0000, out_valid at accept+17; -0.5 (64'hFFFF_8000_0000_0000)
//   -> 32'hBF00_0000 at accept+18; in 0 -> 32'h0000_0000 at accept+1; 64'h8000_0000_0000_0000 -> 32'hC700_0000.
//  i32 in 64'hFFFE_8000_0000_0000 (-1.5) -> 32'hFFFF_FFFF; 64'h0002_C000_0000_0000 (2.75) -> 32'h0000_0002;
//   u32 on -1.5 -> 32'h0000_0000; u32 on 64'h7FFF_FFFF_FFFF_FFFF -> 32'h0000_7FFF; all at accept+1.
//  in_dst=2'b11, any data -> out_err=1, out_data=0 at accept+1.
//  Backpressure: hold out_ready=0 5 cycles after out_valid -> out_data stable, in_ready=0, new in_valid ignored;
//   raise out_ready -> out_valid falls, in_ready=1 next cycle, next input accepted.
//  rst_n pulsed low mid-NORM (fp32 of 2^-48) -> immediate IDLE; no out_valid; back-to-back conversions resume correctly.

Source files
------------

// File: rtl/fpu_output_cvt_if.sv
// FPU writeback bus: result in from the FPU, 32-bit register value out.
// master drives the FPU side and consumes the result; slave is the converter.
interface fpu_output_cvt_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_dst;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  modport master (
    output in_valid, in_dst, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_dst, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/fpu_output_cvt.sv
// Converts a signed Q15.48 FPU result to fp32 / u32 / i32 for the register write port.
// Latency: int/illegal/zero 1 cycle; fp32 2+(63-p) cycles for leading one at bit p (max 65).
// Backpressure: one conversion in flight; result held in DONE until out_ready, in_ready low meanwhile.
module fpu_output_cvt #(
  parameter int FRAC_BITS = 48,
  parameter int FP_BIAS   = 127
) (
  input logic               clk,
  input logic               rst_n,
  fpu_output_cvt_if.slave   bus
);
  localparam int         INT_BITS = 64 - FRAC_BITS;
  localparam logic [7:0] EXP_INIT = 8'(FP_BIAS + 63 - FRAC_BITS);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state;
  logic [63:0] mag;
  logic [7:0]  exp_q;
  logic        sign_q;
  logic [31:0] data_q;
  logic        err_q;

  logic                sign_in;
  logic [63:0]         mag_in;
  logic [INT_BITS-1:0] int_part;
  logic                frac_nz;
  logic [31:0]         conv_data;
  logic                conv_err;

  assign sign_in  = bus.in_data[63];
  assign mag_in   = sign_in ? (~bus.in_data + 64'd1) : bus.in_data;
  assign int_part = bus.in_data[63:FRAC_BITS];
  assign frac_nz  = |bus.in_data[FRAC_BITS-1:0];

  // Integer destinations resolve in one step; fp32 goes through NORM instead.
  always_comb begin
    conv_data = 32'd0;
    conv_err  = 1'b0;
    case (bus.in_dst)
      2'b01:   conv_data = sign_in ? 32'd0 : {{(32-INT_BITS){1'b0}}, int_part};
      2'b10:   conv_data = {{(32-INT_BITS){int_part[INT_BITS-1]}}, int_part}
                           + {31'd0, sign_in & frac_nz};
      2'b11:   conv_err  = 1'b1;
      default: conv_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mag    <= 64'd0;
      exp_q  <= 8'd0;
      sign_q <= 1'b0;
      data_q <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q <= sign_in;
            if (bus.in_dst == 2'b00 && mag_in != 64'd0) begin
              mag   <= mag_in;
              exp_q <= EXP_INIT;
              state <= NORM;
            end else begin
              // Zero in fp32 drops the sign and packs as +0.
              data_q <= conv_data;
              err_q  <= conv_err;
              state  <= DONE;
            end
          end
        end
        NORM: begin
          if (mag[63]) begin
            data_q <= {sign_q, exp_q, mag[62:40]};
            err_q  <= 1'b0;
            state  <= DONE;
          end else begin
            mag   <= mag << 1;
            exp_q <= exp_q - 8'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_err   = err_q;
endmodule
